mano_io_unit: RTL and testbench
===============================

# mano_io_unit

Character I/O unit of the Mano basic computer. It sits between the external character source/sink (io_fgiset, io_fgoset, io_inpr) and the CPU datapath/control. It holds INPR, OUTR, FGI, FGO, IEN and the interrupt request flip-flop R. It synchronises the asynchronous external flag-set strobes and answers the CPU's INP, OUT, SKI, SKO, ION and IOF register-reference I/O instructions.

## Interface
- CHAR_W, 8, character width of INPR/OUTR
- io_clock  in  1  system clock, all state updates on rising edge
- io_reset  in  1  asynchronous, active-high reset
- io_fgiset  in  1  external "input character ready" strobe, asynchronous to io_clock
- io_inpr  in  CHAR_W  external input character; stable while io_fgiset is high
- io_fgoset  in  1  external "output character consumed" strobe, asynchronous
- io_outr  out  CHAR_W  OUTR register contents
- io_outvalid  out  1  ~FGO: OUTR holds an unconsumed character
- io_overrun  out  1  sticky: input character arrived while FGI=1 (character dropped)
- cpu_inp  in  1  INP execute cycle: read INPR, clear FGI
- cpu_out  in  1  OUT execute cycle: OUTR<-cpu_ac_lo, clear FGO
- cpu_ac_lo  in  CHAR_W  AC(0..7) from datapath
- cpu_ski / cpu_sko  in  1  skip-on-FGI / skip-on-FGO query
- cpu_ion / cpu_iof  in  1  set / clear IEN
- cpu_r_window  in  1  high when T0'T1'T2' holds (R may be set this cycle)
- cpu_int_ack  in  1  interrupt cycle taken: clear R and IEN
- cpu_inpr  out  CHAR_W  INPR register contents
- cpu_skip  out  1  combinational (cpu_ski & FGI) | (cpu_sko & FGO)
- cpu_fgi, cpu_fgo, cpu_ien, cpu_r  out  1  flag register values

## Operation
- Strobe capture: io_fgiset and io_fgoset each pass through a 2-flop synchroniser and a third flop for rising-edge detection. One detected edge = one event; a held level produces no further events.
- Input event:
  - FGI=0: INPR<-io_inpr and FGI<-1.
  - FGI=1 and no cpu_inp in the same cycle: character dropped, INPR unchanged, io_overrun<-1.
- cpu_inp: FGI<-0. cpu_inpr presents the pre-edge INPR value.
- Simultaneous input event and cpu_inp: load wins. INPR<-io_inpr, FGI stays 1, no overrun.
- Output event: FGO<-1. It is ignored if FGO is already 1.
- cpu_out: OUTR<-cpu_ac_lo and FGO<-0. It always loads, even when FGO=0.
- Simultaneous cpu_out and output event: cpu_out wins (FGO=0, new OUTR). The event is discarded.
- IEN:
  - cpu_ion sets IEN.
  - cpu_iof or cpu_int_ack clears IEN.
  - Clear wins over set.
- R:
  - Set when cpu_r_window & IEN & (FGI|FGO).
  - Cleared by cpu_int_ack; clear wins over set.
  - R holds otherwise.
- io_overrun clears only on io_reset.
- Reset values (asynchronous):
  - INPR=0, OUTR=0, FGI=0, FGO=1 (sink ready), IEN=0, R=0, overrun=0.
  - All synchroniser/edge flops=0.
  - Resulting outputs: io_outvalid=0, cpu_skip follows its equation.
- io_fgiset/io_fgoset held high across reset release: this is detected as one rising edge after release.
- Reset asserted mid-operation discards any in-flight synchroniser event.

## Timing
- External strobe sampled high first at edge k (sync flop 1). The event takes effect at edge k+2: FGI/FGO and INPR update, visible after k+2.
- io_inpr must be stable from the edge before k through edge k+2. io_fgiset must stay high ≥1 full clock and low ≥1 full clock between characters.
- CPU controls (cpu_inp, cpu_out, cpu_ion, cpu_iof, cpu_int_ack) are single-cycle qualified strobes. They take effect at the edge that ends the cycle in which they are high.
- cpu_skip, cpu_inpr and all flag outputs are available in the same cycle with no added latency (register outputs or combinational from registers).
- R set by the window at edge n is visible after edge n.
- Minimum external-to-CPU latency: 3 clock edges.

## Test plan
- Reset: assert io_reset mid-clock → immediately INPR=0, OUTR=0, FGI=0, FGO=1, IEN=0, R=0, io_overrun=0, io_outvalid=0.
- Input: io_inpr=8'h41, io_fgiset pulsed 2 cycles → cpu_fgi=1 and cpu_inpr=8'h41 at exactly the 3rd edge after first high sample. cpu_ski=1 gives cpu_skip=1. cpu_inp for one cycle → FGI=0.
- Overrun: 8'h41 loaded; second pulse with 8'h42 and no cpu_inp → INPR stays 8'h41, io_overrun=1. Repeat with cpu_inp coincident with the event edge → INPR=8'h42, FGI=1, no overrun.
- Output: cpu_out with cpu_ac_lo=8'h5A → io_outr=8'h5A, io_outvalid=1, FGO=0. io_fgoset pulse → FGO=1 three edges later. cpu_out coincident with the event edge → FGO stays 0.
- Interrupt: cpu_ion, then input event with cpu_r_window=1 → cpu_r=1. cpu_int_ack → R=0, IEN=0. Check cpu_ion+cpu_iof in the same cycle → IEN=0.
- Level hold: io_fgiset held high 20 cycles → exactly one input event. Held high across io_reset release → one event after release.

Source files
------------

// File: rtl/mano_io_unit.sv
// Mano basic computer character I/O unit: INPR/OUTR, FGI/FGO, IEN, R.
// External flag strobes are synchronised and edge-detected before use.
module mano_io_unit #(
  parameter int CHAR_W = 8
) (
  input  logic              io_clock,
  input  logic              io_reset,
  input  logic              io_fgiset,
  input  logic [CHAR_W-1:0] io_inpr,
  input  logic              io_fgoset,
  output logic [CHAR_W-1:0] io_outr,
  output logic              io_outvalid,
  output logic              io_overrun,
  input  logic              cpu_inp,
  input  logic              cpu_out,
  input  logic [CHAR_W-1:0] cpu_ac_lo,
  input  logic              cpu_ski,
  input  logic              cpu_sko,
  input  logic              cpu_ion,
  input  logic              cpu_iof,
  input  logic              cpu_r_window,
  input  logic              cpu_int_ack,
  output logic [CHAR_W-1:0] cpu_inpr,
  output logic              cpu_skip,
  output logic              cpu_fgi,
  output logic              cpu_fgo,
  output logic              cpu_ien,
  output logic              cpu_r
);

  logic [2:0]        fgi_sync_q, fgo_sync_q;
  logic [CHAR_W-1:0] inpr_q, inpr_d;
  logic [CHAR_W-1:0] outr_q, outr_d;
  logic              fgi_q, fgi_d;
  logic              fgo_q, fgo_d;
  logic              ien_q, ien_d;
  logic              r_q, r_d;
  logic              ovr_q, ovr_d;
  logic              ev_in, ev_out;

  // [0],[1] synchronise; [2] remembers the previous level for edge detect
  assign ev_in  = fgi_sync_q[1] & ~fgi_sync_q[2];
  assign ev_out = fgo_sync_q[1] & ~fgo_sync_q[2];

  always_comb begin
    inpr_d = inpr_q;
    outr_d = outr_q;
    fgi_d  = fgi_q;
    fgo_d  = fgo_q;
    ien_d  = ien_q;
    r_d    = r_q;
    ovr_d  = ovr_q;

    if (ev_in) begin
      if (!fgi_q || cpu_inp) begin
        inpr_d = io_inpr;
        fgi_d  = 1'b1;
      end else begin
        ovr_d  = 1'b1;
      end
    end else if (cpu_inp) begin
      fgi_d = 1'b0;
    end

    if (cpu_out) begin
      outr_d = cpu_ac_lo;
      fgo_d  = 1'b0;
    end else if (ev_out) begin
      fgo_d  = 1'b1;
    end

    if (cpu_iof || cpu_int_ack) begin
      ien_d = 1'b0;
    end else if (cpu_ion) begin
      ien_d = 1'b1;
    end

    if (cpu_int_ack) begin
      r_d = 1'b0;
    end else if (cpu_r_window && ien_q && (fgi_q || fgo_q)) begin
      r_d = 1'b1;
    end
  end

  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      fgi_sync_q <= '0;
      fgo_sync_q <= '0;
      inpr_q     <= '0;
      outr_q     <= '0;
      fgi_q      <= 1'b0;
      fgo_q      <= 1'b1;
      ien_q      <= 1'b0;
      r_q        <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      fgi_sync_q <= {fgi_sync_q[1:0], io_fgiset};
      fgo_sync_q <= {fgo_sync_q[1:0], io_fgoset};
      inpr_q     <= inpr_d;
      outr_q     <= outr_d;
      fgi_q      <= fgi_d;
      fgo_q      <= fgo_d;
      ien_q      <= ien_d;
      r_q        <= r_d;
      ovr_q      <= ovr_d;
    end
  end

  assign io_outr     = outr_q;
  assign io_outvalid = ~fgo_q;
  assign io_overrun  = ovr_q;
  assign cpu_inpr    = inpr_q;
  assign cpu_skip    = (cpu_ski & fgi_q) | (cpu_sko & fgo_q);
  assign cpu_fgi     = fgi_q;
  assign cpu_fgo     = fgo_q;
  assign cpu_ien     = ien_q;
  assign cpu_r       = r_q;

endmodule

// File: tb/tb_mano_io_unit.sv
// Bench for mano_io_unit: directed test-plan sequences plus random
// traffic, every cycle compared against a flag-level reference model.
module tb_mano_io_unit;

  localparam int W = 8;

  logic         io_clock = 1'b0;
  logic         io_reset;
  logic         io_fgiset, io_fgoset;
  logic [W-1:0] io_inpr;
  logic [W-1:0] io_outr;
  logic         io_outvalid, io_overrun;
  logic         cpu_inp, cpu_out, cpu_ski, cpu_sko;
  logic         cpu_ion, cpu_iof, cpu_r_window, cpu_int_ack;
  logic [W-1:0] cpu_ac_lo, cpu_inpr;
  logic         cpu_skip, cpu_fgi, cpu_fgo, cpu_ien, cpu_r;

  mano_io_unit #(.CHAR_W(W)) dut (
    .io_clock(io_clock), .io_reset(io_reset),
    .io_fgiset(io_fgiset), .io_inpr(io_inpr),
    .io_fgoset(io_fgoset), .io_outr(io_outr),
    .io_outvalid(io_outvalid), .io_overrun(io_overrun),
    .cpu_inp(cpu_inp), .cpu_out(cpu_out),
    .cpu_ac_lo(cpu_ac_lo), .cpu_ski(cpu_ski),
    .cpu_sko(cpu_sko), .cpu_ion(cpu_ion),
    .cpu_iof(cpu_iof), .cpu_r_window(cpu_r_window),
    .cpu_int_ack(cpu_int_ack), .cpu_inpr(cpu_inpr),
    .cpu_skip(cpu_skip), .cpu_fgi(cpu_fgi),
    .cpu_fgo(cpu_fgo), .cpu_ien(cpu_ien), .cpu_r(cpu_r)
  );

  always #5 io_clock = ~io_clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model: strobe levels seen at the last three edges, newest first
  logic [W-1:0] m_inpr, m_outr;
  logic         m_fgi, m_fgo, m_ien, m_r, m_ovr;
  logic         hi [3];
  logic         ho [3];

  task automatic m_reset();
    m_inpr = '0; m_outr = '0;
    m_fgi = 0; m_fgo = 1; m_ien = 0; m_r = 0; m_ovr = 0;
    for (int i = 0; i < 3; i++) begin hi[i] = 0; ho[i] = 0; end
  endtask

  // One clock edge; an event lands two edges after the first high sample
  task automatic m_edge();
    logic ei, eo;
    logic [W-1:0] n_inpr, n_outr;
    logic n_fgi, n_fgo, n_ien, n_r, n_ovr;
    if (io_reset) begin m_reset(); return; end
    ei = hi[1] && !hi[2];
    eo = ho[1] && !ho[2];
    n_inpr = m_inpr; n_outr = m_outr;
    n_fgi = m_fgi; n_fgo = m_fgo;
    n_ien = m_ien; n_r = m_r; n_ovr = m_ovr;
    if (cpu_inp) n_fgi = 0;
    if (ei) begin
      if (m_fgi && !cpu_inp) n_ovr = 1;
      else begin n_inpr = io_inpr; n_fgi = 1; end
    end
    if (eo) n_fgo = 1;
    if (cpu_out) begin n_outr = cpu_ac_lo; n_fgo = 0; end
    if (cpu_ion) n_ien = 1;
    if (cpu_iof || cpu_int_ack) n_ien = 0;
    if (cpu_r_window && m_ien && (m_fgi || m_fgo)) n_r = 1;
    if (cpu_int_ack) n_r = 0;
    m_inpr = n_inpr; m_outr = n_outr;
    m_fgi = n_fgi; m_fgo = n_fgo;
    m_ien = n_ien; m_r = n_r; m_ovr = n_ovr;
    hi[2] = hi[1]; hi[1] = hi[0]; hi[0] = io_fgiset;
    ho[2] = ho[1]; ho[1] = ho[0]; ho[0] = io_fgoset;
  endtask

  task automatic compare_all();
    check("outr",     32'(io_outr),     32'(m_outr));
    check("outvalid", 32'(io_outvalid), 32'(!m_fgo));
    check("overrun",  32'(io_overrun),  32'(m_ovr));
    check("inpr",     32'(cpu_inpr),    32'(m_inpr));
    check("skip",     32'(cpu_skip),
          32'((cpu_ski && m_fgi) || (cpu_sko && m_fgo)));
    check("fgi",      32'(cpu_fgi),     32'(m_fgi));
    check("fgo",      32'(cpu_fgo),     32'(m_fgo));
    check("ien",      32'(cpu_ien),     32'(m_ien));
    check("r",        32'(cpu_r),       32'(m_r));
  endtask

  task automatic tick();
    @(posedge io_clock);
    m_edge();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle();
    cpu_inp = 0; cpu_out = 0; cpu_ski = 0; cpu_sko = 0;
    cpu_ion = 0; cpu_iof = 0; cpu_r_window = 0;
    cpu_int_ack = 0; cpu_ac_lo = '0;
  endtask

  task automatic mid_reset();
    @(negedge io_clock);
    #2 io_reset = 1;
    #1 m_reset();
    compare_all();
    check("rst_inpr", 32'(cpu_inpr), 32'h0);
    check("rst_fgo",  32'(cpu_fgo),  32'h1);
    tick();
    io_reset = 0;
  endtask

  int lo_i, hi_i, lo_o, hi_o;

  initial begin
    io_reset = 0; io_fgiset = 0; io_fgoset = 0;
    io_inpr = '0;
    idle();
    m_reset();
    mid_reset();
    ticks(2);

    // input character, skip, then INP
    io_inpr = 8'h41; io_fgiset = 1;
    tick();
    tick();
    io_fgiset = 0;
    check("fgi_early", 32'(cpu_fgi), 32'h0);
    tick();
    check("fgi_k2", 32'(cpu_fgi), 32'h1);
    check("inpr_41", 32'(cpu_inpr), 32'h41);
    cpu_ski = 1; #1;
    check("ski_skip", 32'(cpu_skip), 32'h1);
    ticks(2);
    cpu_ski = 0;
    // overrun: second character without INP
    io_inpr = 8'h42; io_fgiset = 1;
    tick(); io_fgiset = 0;
    ticks(3);
    check("ovr_inpr", 32'(cpu_inpr), 32'h41);
    check("ovr_set", 32'(io_overrun), 32'h1);
    mid_reset();
    // INP coincident with the event edge: load wins
    io_inpr = 8'h41; io_fgiset = 1;
    tick(); io_fgiset = 0; ticks(4);
    io_inpr = 8'h42; io_fgiset = 1;
    tick(); io_fgiset = 0; tick();
    cpu_inp = 1; tick(); cpu_inp = 0;
    check("coinc_inpr", 32'(cpu_inpr), 32'h42);
    check("coinc_fgi", 32'(cpu_fgi), 32'h1);
    check("coinc_ovr", 32'(io_overrun), 32'h0);

    // output path
    cpu_out = 1; cpu_ac_lo = 8'h5A; tick(); cpu_out = 0;
    check("outr_5a", 32'(io_outr), 32'h5A);
    check("outvalid", 32'(io_outvalid), 32'h1);
    io_fgoset = 1; tick(); io_fgoset = 0; tick();
    check("fgo_early", 32'(cpu_fgo), 32'h0);
    tick();
    check("fgo_k2", 32'(cpu_fgo), 32'h1);
    cpu_out = 1; cpu_ac_lo = 8'h11; tick(); cpu_out = 0;
    io_fgoset = 1; tick(); io_fgoset = 0; tick();
    cpu_out = 1; cpu_ac_lo = 8'h22; tick(); cpu_out = 0;
    check("out_wins", 32'(cpu_fgo), 32'h0);
    ticks(3);

    // interrupt
    cpu_ion = 1; tick(); cpu_ion = 0;
    io_inpr = 8'h33; io_fgiset = 1; tick(); io_fgiset = 0;
    cpu_r_window = 1; ticks(4); cpu_r_window = 0;
    check("r_set", 32'(cpu_r), 32'h1);
    cpu_int_ack = 1; tick(); cpu_int_ack = 0;
    check("ack_r", 32'(cpu_r), 32'h0);
    check("ack_ien", 32'(cpu_ien), 32'h0);
    cpu_ion = 1; cpu_iof = 1; tick(); idle();
    check("ion_iof", 32'(cpu_ien), 32'h0);

    // level hold and hold across reset release
    cpu_inp = 1; tick(); cpu_inp = 0;
    io_inpr = 8'h77; io_fgiset = 1;
    tick(); tick(); tick();
    cpu_inp = 1; tick(); cpu_inp = 0;
    ticks(17);
    check("hold_once", 32'(cpu_fgi), 32'h0);
    mid_reset();
    ticks(3);
    check("hold_rst", 32'(cpu_fgi), 32'h1);
    io_fgiset = 0;
    ticks(4);

    // random traffic with legal strobe spacing
    lo_i = 3; hi_i = 0; lo_o = 3; hi_o = 0;
    for (int c = 0; c < 2000; c++) begin
      if (hi_i > 0) begin
        hi_i--;
        if (hi_i == 0) begin io_fgiset = 0; lo_i = $urandom_range(6, 3); end
      end else if (lo_i > 0) lo_i--;
      else if ($urandom_range(3) == 0) begin
        io_inpr = W'($urandom); io_fgiset = 1;
        hi_i = $urandom_range(4, 1);
      end
      if (hi_o > 0) begin
        hi_o--;
        if (hi_o == 0) begin io_fgoset = 0; lo_o = $urandom_range(6, 3); end
      end else if (lo_o > 0) lo_o--;
      else if ($urandom_range(3) == 0) begin
        io_fgoset = 1; hi_o = $urandom_range(4, 1);
      end
      cpu_inp      = ($urandom_range(5) == 0);
      cpu_out      = ($urandom_range(5) == 0);
      cpu_ac_lo    = W'($urandom);
      cpu_ski      = $urandom_range(1) == 1;
      cpu_sko      = $urandom_range(1) == 1;
      cpu_ion      = ($urandom_range(6) == 0);
      cpu_iof      = ($urandom_range(9) == 0);
      cpu_r_window = $urandom_range(1) == 1;
      cpu_int_ack  = ($urandom_range(9) == 0);
      #1 compare_all();
      if (c == 1000) mid_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
